// File: rtl/mac_lookup_initiator.sv
// rtl/mac_lookup_initiator.sv - frame-header client of the MAC search engine: learn SA, look up DA, aging sweep requests
module mac_lookup_initiator #(
    parameter logic [31:0] AGING_PERIOD = 32'd50_000_000,
    parameter logic [11:0] SE_TIMEOUT   = 12'd2047,
    parameter logic [15:0] PORT_MASK    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] hdr_da,
    input  logic [47:0] hdr_sa,
    input  logic [3:0]  hdr_src_port,
    output logic        fwd_valid,
    input  logic        fwd_ready,
    output logic [15:0] fwd_portmap,
    output logic        fwd_flood,
    output logic        se_source,
    output logic [47:0] se_mac,
    output logic [15:0] se_portmap,
    output logic [9:0]  se_hash,
    output logic        se_req,
    input  logic        se_ack,
    input  logic        se_nak,
    input  logic [15:0] se_result,
    output logic        aging_req,
    input  logic        aging_ack,
    output logic [15:0] stat_learn_fail,
    output logic [15:0] stat_miss,
    output logic [15:0] stat_timeout,
    output logic [15:0] stat_age_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEARN,
        S_GAP,
        S_LOOKUP,
        S_OUT
    } state_t;

    // Fold the 48-bit MAC into a 10-bit bucket index.
    function automatic logic [9:0] mac_hash(input logic [47:0] m);
        return m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b00, m[47:40]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [47:0] da_q, da_d;
    logic [15:0] src_oh_q, src_oh_d;
    logic [11:0] wait_q, wait_d;
    logic        hdr_ready_q, hdr_ready_d;
    logic        fwd_valid_q, fwd_valid_d;
    logic [15:0] fwd_portmap_q, fwd_portmap_d;
    logic        fwd_flood_q, fwd_flood_d;
    logic        se_source_q, se_source_d;
    logic [47:0] se_mac_q, se_mac_d;
    logic [15:0] se_portmap_q, se_portmap_d;
    logic [9:0]  se_hash_q, se_hash_d;
    logic        se_req_q, se_req_d;
    logic [15:0] stat_learn_fail_q, stat_learn_fail_d;
    logic [15:0] stat_miss_q, stat_miss_d;
    logic [15:0] stat_timeout_q, stat_timeout_d;
    logic [15:0] stat_age_overrun_q, stat_age_overrun_d;
    logic [31:0] age_cnt_q, age_cnt_d;
    logic        aging_req_q, aging_req_d;

    logic        accept;
    logic        wait_expired;
    logic        age_tick;
    logic [15:0] hdr_oh;

    assign accept       = hdr_valid && hdr_ready_q;
    assign wait_expired = (wait_q == SE_TIMEOUT - 12'd1);
    assign hdr_oh       = 16'd1 << hdr_src_port;
    assign age_tick     = (age_cnt_q == AGING_PERIOD - 32'd1);

    // Request sequencer: learn SA, one-cycle gap, look up DA, present result.
    always_comb begin
        state_d           = state_q;
        da_d              = da_q;
        src_oh_d          = src_oh_q;
        wait_d            = wait_q;
        hdr_ready_d       = hdr_ready_q;
        fwd_valid_d       = fwd_valid_q;
        fwd_portmap_d     = fwd_portmap_q;
        fwd_flood_d       = fwd_flood_q;
        se_source_d       = se_source_q;
        se_mac_d          = se_mac_q;
        se_portmap_d      = se_portmap_q;
        se_hash_d         = se_hash_q;
        se_req_d          = se_req_q;
        stat_learn_fail_d = stat_learn_fail_q;
        stat_miss_d       = stat_miss_q;
        stat_timeout_d    = stat_timeout_q;

        case (state_q)
            S_IDLE: begin
                hdr_ready_d = 1'b1;
                if (accept) begin
                    hdr_ready_d = 1'b0;
                    da_d        = hdr_da;
                    src_oh_d    = hdr_oh;
                    wait_d      = 12'd0;
                    if (!hdr_sa[40]) begin
                        state_d      = S_LEARN;
                        se_req_d     = 1'b1;
                        se_source_d  = 1'b1;
                        se_mac_d     = hdr_sa;
                        se_hash_d    = mac_hash(hdr_sa);
                        se_portmap_d = hdr_oh;
                    end else if (!hdr_da[40]) begin
                        state_d      = S_LOOKUP;
                        se_req_d     = 1'b1;
                        se_source_d  = 1'b0;
                        se_mac_d     = hdr_da;
                        se_hash_d    = mac_hash(hdr_da);
                        se_portmap_d = 16'd0;
                    end else begin
                        state_d       = S_OUT;
                        fwd_valid_d   = 1'b1;
                        fwd_portmap_d = PORT_MASK & ~hdr_oh;
                        fwd_flood_d   = 1'b1;
                    end
                end
            end

            S_LEARN: begin
                wait_d = wait_q + 12'd1;
                if (se_ack || se_nak || wait_expired) begin
                    se_req_d = 1'b0;
                    state_d  = S_GAP;
                    if (!se_ack && se_nak) begin
                        stat_learn_fail_d = sat_inc(stat_learn_fail_q);
                    end else if (!se_ack) begin
                        stat_timeout_d = sat_inc(stat_timeout_q);
                    end
                end
            end

            // One idle cycle so the responder cannot mistake the lookup for a held learn.
            S_GAP: begin
                if (da_q[40]) begin
                    state_d       = S_OUT;
                    fwd_valid_d   = 1'b1;
                    fwd_portmap_d = PORT_MASK & ~src_oh_q;
                    fwd_flood_d   = 1'b1;
                end else begin
                    state_d      = S_LOOKUP;
                    wait_d       = 12'd0;
                    se_req_d     = 1'b1;
                    se_source_d  = 1'b0;
                    se_mac_d     = da_q;
                    se_hash_d    = mac_hash(da_q);
                    se_portmap_d = 16'd0;
                end
            end

            S_LOOKUP: begin
                wait_d = wait_q + 12'd1;
                if (se_ack) begin
                    se_req_d      = 1'b0;
                    state_d       = S_OUT;
                    fwd_valid_d   = 1'b1;
                    fwd_portmap_d = se_result & ~src_oh_q;
                    fwd_flood_d   = 1'b0;
                end else if (se_nak || wait_expired) begin
                    se_req_d      = 1'b0;
                    state_d       = S_OUT;
                    fwd_valid_d   = 1'b1;
                    fwd_portmap_d = PORT_MASK & ~src_oh_q;
                    fwd_flood_d   = 1'b1;
                    if (se_nak) begin
                        stat_miss_d = sat_inc(stat_miss_q);
                    end else begin
                        stat_timeout_d = sat_inc(stat_timeout_q);
                    end
                end
            end

            S_OUT: begin
                if (fwd_ready) begin
                    fwd_valid_d = 1'b0;
                    hdr_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                se_req_d    = 1'b0;
                fwd_valid_d = 1'b0;
            end
        endcase
    end

    // Free-running aging timer; a tick while a sweep is still pending is counted, not queued.
    always_comb begin
        age_cnt_d          = age_tick ? 32'd0 : age_cnt_q + 32'd1;
        aging_req_d        = aging_req_q;
        stat_age_overrun_d = stat_age_overrun_q;
        if (aging_req_q && aging_ack) begin
            aging_req_d = 1'b0;
        end
        if (age_tick) begin
            if (aging_req_q) begin
                stat_age_overrun_d = sat_inc(stat_age_overrun_q);
            end else begin
                aging_req_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset discards any in-flight request or result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            da_q               <= 48'd0;
            src_oh_q           <= 16'd0;
            wait_q             <= 12'd0;
            hdr_ready_q        <= 1'b0;
            fwd_valid_q        <= 1'b0;
            fwd_portmap_q      <= 16'd0;
            fwd_flood_q        <= 1'b0;
            se_source_q        <= 1'b0;
            se_mac_q           <= 48'd0;
            se_portmap_q       <= 16'd0;
            se_hash_q          <= 10'd0;
            se_req_q           <= 1'b0;
            stat_learn_fail_q  <= 16'd0;
            stat_miss_q        <= 16'd0;
            stat_timeout_q     <= 16'd0;
            stat_age_overrun_q <= 16'd0;
            age_cnt_q          <= 32'd0;
            aging_req_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            da_q               <= da_d;
            src_oh_q           <= src_oh_d;
            wait_q             <= wait_d;
            hdr_ready_q        <= hdr_ready_d;
            fwd_valid_q        <= fwd_valid_d;
            fwd_portmap_q      <= fwd_portmap_d;
            fwd_flood_q        <= fwd_flood_d;
            se_source_q        <= se_source_d;
            se_mac_q           <= se_mac_d;
            se_portmap_q       <= se_portmap_d;
            se_hash_q          <= se_hash_d;
            se_req_q           <= se_req_d;
            stat_learn_fail_q  <= stat_learn_fail_d;
            stat_miss_q        <= stat_miss_d;
            stat_timeout_q     <= stat_timeout_d;
            stat_age_overrun_q <= stat_age_overrun_d;
            age_cnt_q          <= age_cnt_d;
            aging_req_q        <= aging_req_d;
        end
    end

    assign hdr_ready        = hdr_ready_q;
    assign fwd_valid        = fwd_valid_q;
    assign fwd_portmap      = fwd_portmap_q;
    assign fwd_flood        = fwd_flood_q;
    assign se_source        = se_source_q;
    assign se_mac           = se_mac_q;
    assign se_portmap       = se_portmap_q;
    assign se_hash          = se_hash_q;
    assign se_req           = se_req_q;
    assign aging_req        = aging_req_q;
    assign stat_learn_fail  = stat_learn_fail_q;
    assign stat_miss        = stat_miss_q;
    assign stat_timeout     = stat_timeout_q;
    assign stat_age_overrun = stat_age_overrun_q;

endmodule

// File: doc/mac_lookup_initiator.md
Name: mac_lookup_initiator

Overview:
Requesting side of the MAC search-engine interface: the frame-header-side client of the 2-bucket hash table.
- For each received frame header, it issues a source-learning request for SA, then a destination lookup for DA.
- It returns a forwarding portmap to the forwarding path.
- It also generates the periodic aging sweep request (aging_req/aging_ack) toward the table.

Parameters:
AGING_PERIOD, 32'd50_000_000, cycles between aging sweep starts (counted from previous start).
SE_TIMEOUT, 12'd2047, max cycles se_req held without se_ack/se_nak before abort (exceeds the 1024-cycle post-reset table clear).
PORT_MASK, 16'hFFFF, set of existing ports used for flooding.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
hdr_valid  in  1  frame header available.
hdr_ready  out  1  header accepted when hdr_valid&hdr_ready.
hdr_da  in  48  destination MAC, first octet in [47:40].
hdr_sa  in  48  source MAC.
hdr_src_port  in  4  ingress port number.
fwd_valid  out  1  forwarding result valid.
fwd_ready  in  1  result consumed when fwd_valid&fwd_ready.
fwd_portmap  out  16  egress portmap.
fwd_flood  out  1  result is a flood (DA group or lookup miss).
se_source  out  1  1=learn(SA), 0=lookup(DA).
se_mac  out  48  MAC under request.
se_portmap  out  16  one-hot ingress port, learn only.
se_hash  out  10  bucket index.
se_req  out  1  request, level, held until se_ack/se_nak.
se_ack  in  1  single-cycle success pulse.
se_nak  in  1  single-cycle fail/miss pulse.
se_result  in  16  lookup portmap, valid with se_ack.
aging_req  out  1  aging sweep request, level.
aging_ack  in  1  single-cycle sweep-complete pulse.
stat_learn_fail  out  16  saturating count of learn naks (bucket full).
stat_miss  out  16  saturating count of lookup naks.
stat_timeout  out  16  saturating count of request timeouts.
stat_age_overrun  out  16  saturating count of aging ticks during an active sweep.

Behaviour:
- Reset (rst=1 at a clk edge) drives all outputs to 0 on that edge, except hdr_ready=1 only after reset deasserts; the aging timer is cleared.
- Reset mid-operation drops any in-flight request and result.
- All outputs are registered.
- Hash: h = m[9:0]^m[19:10]^m[29:20]^m[39:30]^{2'b00,m[47:40]}, computed on the MAC being requested.
- Group address: da[40]=1. Same test applied to SA.
- FSM states: IDLE, LEARN, GAP, LOOKUP, OUT.
  - IDLE: hdr_ready=1. On accept, latch da, sa, src_port, and src_oh = 1<<src_port.
    - SA unicast -> LEARN.
    - SA group, DA unicast -> LOOKUP.
    - Both group -> OUT with flood.
  - LEARN: se_req=1, se_source=1, se_mac=sa, se_hash=h(sa), se_portmap=src_oh. All fields stable while se_req=1.
    - On se_ack -> GAP.
    - On se_nak -> stat_learn_fail++, then GAP.
  - GAP: se_req=0 for exactly 1 cycle. This guarantees the responder is not re-triggered.
    - DA group -> OUT, flood.
    - Otherwise -> LOOKUP.
  - LOOKUP: se_req=1, se_source=0, se_mac=da, se_hash=h(da), se_portmap=0.
    - se_ack -> fwd_portmap = se_result & ~src_oh, fwd_flood=0.
    - se_nak -> stat_miss++, fwd_portmap = PORT_MASK & ~src_oh, fwd_flood=1.
  - OUT: fwd_valid=1, held stable until fwd_ready. fwd_valid drops on the handshake cycle edge -> IDLE.
  - A result with an empty portmap is still presented (filtered frame).
- se_req drops on the edge after se_ack/se_nak is sampled.
- se_ack/se_nak seen outside LEARN/LOOKUP are ignored.
- Timeout: a wait counter resets on entry to LEARN/LOOKUP. When it reaches SE_TIMEOUT with no response, treat as se_nak for that state and stat_timeout++.
- Latency: header accept at T, se_req high from T+1.
- Aging: free-running counter to AGING_PERIOD-1, then wraps.
  - At wrap, if aging_req=0, set aging_req=1.
  - aging_req stays high until the cycle aging_ack is sampled, and clears on the next edge.
  - A wrap while aging_req=1 -> stat_age_overrun++; the tick is not queued.
  - Aging runs independently of the FSM; the responder arbitrates se_req over aging_req.
- All stat counters saturate at 16'hFFFF.

Test Plan:
- Reset, then header SA=48'h0000_0000_0001, DA=48'h0000_0000_0002, src_port=3:
  - learn se_req at T+1 with se_hash=10'h001, se_portmap=16'h0008; model acks.
  - se_req low for exactly 1 cycle.
  - lookup se_hash=10'h002; model naks -> fwd_portmap=16'hFFF7, fwd_flood=1, stat_miss=1.
- Same flow, lookup acked with se_result=16'h0020 -> fwd_portmap=16'h0020, fwd_flood=0. Hold fwd_ready=0 for 5 cycles -> output stable, hdr_ready=0.
- DA=48'hFFFF_FFFF_FFFF, src_port=0 -> learn issued, no lookup request, fwd_portmap=16'hFFFE, fwd_flood=1.
- Hit on own port: se_result=16'h0008, src_port=3 -> fwd_portmap=16'h0000, fwd_flood=0. Learn nak first -> stat_learn_fail=1.
- No responder activity, SE_TIMEOUT=20 -> se_req drops after 20 cycles, stat_timeout=1; lookup also times out -> flood result, stat_timeout=2.
- AGING_PERIOD=100 -> aging_req rises at cycle 100 after reset release. Withhold aging_ack past cycle 200 -> stat_age_overrun=1. aging_ack pulse -> aging_req low on the next edge.
